// File: rtl/fir9_stream_driver.sv
// Upstream driver/monitor for the fir9 threshold detector: holds config, streams
// buffered samples into x, and aligns the returned y to report hits per run.
module fir9_stream_driver #(
  parameter int DEPTH   = 8,
  parameter int FIR_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_wr,
  input  logic [3:0]       cfg_addr,
  input  logic [10:0]      cfg_data,
  input  logic             s_valid,
  input  logic [3:0]       s_data,
  output logic             s_ready,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  output logic [3:0]       x,
  output logic [3:0]       c [0:8],
  output logic [10:0]      thresh,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] first_hit_idx,
  output logic             first_hit_vld,
  output logic             underrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FIR_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state;

  logic [3:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             push, pop, hit;
  logic [CNT_W-1:0] n_lat, slot;
  logic [FW-1:0]    flush_cnt;
  logic [FIR_LAT:0] vld_pipe;
  logic [CNT_W-1:0] idx_pipe [FIR_LAT+1];

  assign push      = s_valid && s_ready;
  assign pop       = (state == RUN) && (count != '0);
  assign count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign hit       = vld_pipe[FIR_LAT] && y;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= s_data;

  // s_ready is registered from the next occupancy so it is 0 only in reset or when full
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      s_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nxt;
      s_ready <= (count_nxt != (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) c[i] <= '0;
      thresh <= '0;
    end else if (cfg_wr && state == IDLE) begin
      if (cfg_addr <= 4'd8)       c[cfg_addr] <= cfg_data[3:0];
      else if (cfg_addr == 4'd9) thresh      <= cfg_data;
    end
  end

  // Tag for the slot driven on x this edge; stage FIR_LAT meets the matching y.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i <= FIR_LAT; i++) idx_pipe[i] <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[FIR_LAT-1:0], state == RUN};
      idx_pipe[0] <= slot;
      for (int i = 1; i <= FIR_LAT; i++) idx_pipe[i] <= idx_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      x             <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      n_lat         <= '0;
      slot          <= '0;
      flush_cnt     <= '0;
      hit_count     <= '0;
      first_hit_idx <= '0;
      first_hit_vld <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      done <= 1'b0;
      x    <= '0;
      if (hit) begin
        if (hit_count != '1) hit_count <= hit_count + 1'b1;
        if (!first_hit_vld) begin
          first_hit_idx <= idx_pipe[FIR_LAT];
          first_hit_vld <= 1'b1;
        end
      end
      case (state)
        IDLE: if (start) begin
          n_lat         <= n_samples;
          slot          <= '0;
          hit_count     <= '0;
          first_hit_idx <= '0;
          first_hit_vld <= 1'b0;
          underrun      <= 1'b0;
          if (n_samples == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          // an empty FIFO still consumes the slot: fir9 cannot stall
          x    <= pop ? mem[rd_ptr] : 4'd0;
          slot <= slot + 1'b1;
          if (!pop) underrun <= 1'b1;
          if (slot == n_lat - 1'b1) begin
            state     <= FLUSH;
            flush_cnt <= '0;
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == FW'(FIR_LAT - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir9_stream_driver.sv
// Directed bench for fir9_stream_driver with a behavioural fir9 (9-tap, 3-clock latency).
module tb_fir9_stream_driver;
  localparam int CNT_W = 16;

  logic             clk, rst_n, cfg_wr, s_valid, s_ready, start, y;
  logic [3:0]       cfg_addr, s_data, x;
  logic [10:0]      cfg_data, thresh;
  logic [CNT_W-1:0] n_samples, hit_count, first_hit_idx;
  logic [3:0]       c [0:8];
  logic             busy, done, first_hit_vld, underrun;

  int checks = 0;
  int fails  = 0;
  logic [3:0] x_log [0:63];

  fir9_stream_driver #(.DEPTH(8), .FIR_LAT(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .start(start),
    .n_samples(n_samples), .x(x), .c(c), .thresh(thresh), .y(y), .busy(busy),
    .done(done), .hit_count(hit_count), .first_hit_idx(first_hit_idx),
    .first_hit_vld(first_hit_vld), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fir9 stand-in: y in cycle t+3 reflects the window ending with x of cycle t
  logic [3:0] hist [0:7];
  logic d0, d1, d2;
  assign y = d2;

  function automatic int fir_sum();
    int s = int'(c[0]) * int'(x);
    for (int i = 1; i < 9; i++) s += int'(c[i]) * int'(hist[i-1]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) hist[i] <= '0;
      d0 <= 1'b0; d1 <= 1'b0; d2 <= 1'b0;
    end else begin
      for (int i = 7; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= x;
      d0 <= (fir_sum() >= int'(thresh));
      d1 <= d0;
      d2 <= d1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [10:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic push1(input logic [3:0] d);
    s_valid = 1'b1; s_data = d;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic run_start(input logic [CNT_W-1:0] n);
    start = 1'b1; n_samples = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycle index counts from the start cycle (0); returns -1 if done never came.
  task automatic run_capture(output int dcyc);
    int cyc = 1;
    x_log[1] = x;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      x_log[cyc] = x;
    end
    dcyc = done ? cyc : -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(2);
    checks++; if (x !== 4'd0) begin fails++; $display("FAIL reset_x: got %0d want 0", x); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    checks++; if (hit_count !== '0 || underrun !== 1'b0) begin fails++; $display("FAIL reset_results: hit_count %0d underrun %b want 0 0", hit_count, underrun); end
    rst_n = 1'b1;
    tick(1);
    checks++; if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_config;
    for (int k = 0; k < 9; k++) cfg_write(4'(k), 11'(k + 1));
    cfg_write(4'd9, 11'd50);
    for (int k = 0; k < 9; k++) begin
      checks++; if (c[k] !== 4'(k + 1)) begin fails++; $display("FAIL cfg_c%0d: got %0d want %0d", k, c[k], k + 1); end
    end
    checks++; if (thresh !== 11'd50) begin fails++; $display("FAIL cfg_thresh: got %0d want 50", thresh); end
    run_start(2);
    cfg_write(4'd9, 11'd7);
    tick(10);
    checks++; if (thresh !== 11'd50) begin fails++; $display("FAIL cfg_busy_ignored: got %0d want 50", thresh); end
  endtask

  task automatic test_aligned_hit;
    logic [3:0] smp [8] = '{4'd0, 4'd0, 4'd0, 4'd15, 4'd15, 4'd0, 4'd0, 4'd0};
    int d;
    for (int k = 0; k < 9; k++) cfg_write(4'(k), 11'd1);
    cfg_write(4'd9, 11'd20);
    for (int k = 0; k < 8; k++) push1(smp[k]);
    tick(12);
    run_start(8);
    run_capture(d);
    checks++; if (d !== 12) begin fails++; $display("FAIL hit_done_cycle: got %0d want 12", d); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (x_log[k+2] !== smp[k]) begin fails++; $display("FAIL hit_x_slot%0d: got %0d want %0d", k, x_log[k+2], smp[k]); end
    end
    tick(1);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL hit_done_pulse: done %b busy %b want 0 0", done, busy); end
    checks++; if (hit_count !== 16'd4) begin fails++; $display("FAIL hit_count: got %0d want 4", hit_count); end
    checks++; if (first_hit_idx !== 16'd4 || first_hit_vld !== 1'b1) begin fails++; $display("FAIL hit_first: idx %0d vld %b want 4 1", first_hit_idx, first_hit_vld); end
    checks++; if (underrun !== 1'b0) begin fails++; $display("FAIL hit_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_underrun;
    logic [3:0] exp_x [6] = '{4'd9, 4'd10, 4'd11, 4'd0, 4'd0, 4'd0};
    int d;
    push1(4'd9); push1(4'd10); push1(4'd11);
    run_start(6);
    run_capture(d);
    checks++; if (d !== 10) begin fails++; $display("FAIL underrun_done_cycle: got %0d want 10", d); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (x_log[k+2] !== exp_x[k]) begin fails++; $display("FAIL underrun_x_slot%0d: got %0d want %0d", k, x_log[k+2], exp_x[k]); end
    end
    tick(1);
    checks++; if (underrun !== 1'b1) begin fails++; $display("FAIL underrun_flag: got %b want 1", underrun); end
    checks++; if (hit_count !== 16'd4) begin fails++; $display("FAIL underrun_hits: got %0d want 4", hit_count); end
    checks++; if (first_hit_idx !== 16'd2) begin fails++; $display("FAIL underrun_first: got %0d want 2", first_hit_idx); end
  endtask

  task automatic test_zero_length;
    int d;
    run_start(0);
    run_capture(d);
    checks++; if (d !== 1) begin fails++; $display("FAIL zero_done_cycle: got %0d want 1", d); end
    tick(1);
    checks++; if (hit_count !== '0 || first_hit_vld !== 1'b0) begin fails++; $display("FAIL zero_results: hits %0d vld %b want 0 0", hit_count, first_hit_vld); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL zero_idle: busy %b done %b want 0 0", busy, done); end
  endtask

  task automatic test_fifo_full;
    int pushed = 0;
    int pv = 1;
    int d;
    logic acc;
    s_valid = 1'b1; s_data = 4'd1;
    repeat (10) begin
      acc = s_ready;
      @(negedge clk);
      if (acc) begin pushed++; pv++; s_data = 4'(pv); end
    end
    checks++; if (pushed !== 8) begin fails++; $display("FAIL full_pushes: got %0d want 8", pushed); end
    checks++; if (s_ready !== 1'b0) begin fails++; $display("FAIL full_s_ready: got %b want 0", s_ready); end
    fork
      begin
        repeat (30) begin
          acc = s_valid && s_ready;
          @(negedge clk);
          if (acc) begin pv++; s_data = 4'(pv); end
        end
        s_valid = 1'b0;
      end
      begin
        run_start(12);
        run_capture(d);
      end
    join
    checks++; if (d !== 16) begin fails++; $display("FAIL full_done_cycle: got %0d want 16", d); end
    for (int k = 0; k < 12; k++) begin
      checks++; if (x_log[k+2] !== 4'(k + 1)) begin fails++; $display("FAIL full_order_slot%0d: got %0d want %0d", k, x_log[k+2], k + 1); end
    end
    checks++; if (underrun !== 1'b0) begin fails++; $display("FAIL full_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_reset_mid_run;
    int d;
    run_start(10);
    tick(3);
    rst_n = 1'b0;
    tick(2);
    checks++; if (x !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midrst_ctl: x %0d busy %b done %b want 0 0 0", x, busy, done); end
    checks++; if (hit_count !== '0 || first_hit_vld !== 1'b0) begin fails++; $display("FAIL midrst_results: hits %0d vld %b want 0 0", hit_count, first_hit_vld); end
    checks++; if (c[0] !== 4'd0 || thresh !== 11'd0) begin fails++; $display("FAIL midrst_cfg: c0 %0d thresh %0d want 0 0", c[0], thresh); end
    rst_n = 1'b1;
    tick(1);
    checks++; if (s_ready !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL midrst_ready: s_ready %b done %b want 1 0", s_ready, done); end
    run_start(1);
    run_capture(d);
    checks++; if (d !== 5) begin fails++; $display("FAIL midrst_done_cycle: got %0d want 5", d); end
    checks++; if (x_log[2] !== 4'd0 || underrun !== 1'b1) begin fails++; $display("FAIL midrst_fifo_empty: x %0d underrun %b want 0 1", x_log[2], underrun); end
  endtask

  initial begin
    rst_n = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
    s_valid = 1'b0; s_data = '0; start = 1'b0; n_samples = '0;
    test_reset;
    test_config;
    test_aligned_hit;
    test_underrun;
    test_zero_length;
    test_fifo_full;
    test_reset_mid_run;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end, checks %0d failures %0d", checks, fails);
    $fatal(1);
  end
endmodule
